// File: rtl/edge_pulse_gen.sv
// Multi-channel edge detector with per-channel pulse stretcher and sticky retrigger flags.
// Detection and the stretched output are combinational from in; all state updates on clk.
module edge_pulse_gen #(
  parameter int DW = 1,
  parameter int PW = 1,
  localparam int CW = $clog2(PW + 1)
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          en,
  input  logic [1:0]    mode,
  input  logic          clr,
  input  logic [DW-1:0] in,
  output logic [DW-1:0] edge_det,
  output logic [DW-1:0] out,
  output logic [DW-1:0] retrig
);

  typedef enum logic [1:0] {
    MODE_RISE = 2'b00,
    MODE_FALL = 2'b01,
    MODE_BOTH = 2'b10,
    MODE_NONE = 2'b11
  } mode_t;

  localparam logic [CW-1:0] RELOAD = CW'(PW - 1);

  logic [DW-1:0] in_reg;
  logic [DW-1:0] rise;
  logic [DW-1:0] fall;
  logic [DW-1:0] det;
  logic [DW-1:0] busy;
  logic [CW-1:0] cnt [DW];
  logic          primed;

  always_comb begin
    rise = in & ~in_reg;
    fall = ~in & in_reg;
    case (mode_t'(mode))
      MODE_RISE: det = rise;
      MODE_FALL: det = fall;
      MODE_BOTH: det = rise | fall;
      default:   det = '0;
    endcase
  end

  always_comb begin
    busy = '0;
    for (int i = 0; i < DW; i++) begin
      busy[i] = (cnt[i] != '0);
    end
  end

  // Gating with nreset drops edge/out in the very cycle reset is sampled low.
  assign edge_det = det & {DW{en & primed & nreset}};
  assign out      = (edge_det | busy) & {DW{nreset}};

  always_ff @(posedge clk) begin
    if (!nreset) begin
      in_reg <= '0;
      primed <= 1'b0;
      retrig <= '0;
      for (int i = 0; i < DW; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      // in_reg tracks in unconditionally so a mode or enable change never sees stale history.
      in_reg <= in;
      primed <= 1'b1;
      for (int i = 0; i < DW; i++) begin
        if (edge_det[i]) begin
          cnt[i] <= RELOAD;
        end else if (busy[i]) begin
          cnt[i] <= cnt[i] - CW'(1);
        end
        if (edge_det[i] && busy[i]) begin
          retrig[i] <= 1'b1;
        end else if (clr) begin
          retrig[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_edge_pulse_gen.sv
// Bench for edge_pulse_gen: five DW=4 instances (PW 1,3,4,5,6) plus one DW=1/PW=1 instance share
// the same stimulus; a last-edge-time model checks every cycle, literal pins check the model.
module tb_edge_pulse_gen;

  localparam int NI = 6;

  function automatic int pw_of(int k);
    case (k)
      0: return 1;
      1: return 3;
      2: return 4;
      3: return 5;
      4: return 6;
      default: return 1;
    endcase
  endfunction

  logic       clk = 1'b0;
  logic       nreset = 1'b0;
  logic       en = 1'b1;
  logic [1:0] mode = 2'b01;
  logic       clr = 1'b0;
  logic [3:0] in_v = 4'b0000;

  logic [3:0] edge_a [5];
  logic [3:0] out_a  [5];
  logic [3:0] ret_a  [5];
  logic       e_one, o_one, r_one;

  int total = 0;
  int bad = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  for (genvar g = 0; g < 5; g++) begin : g_dut
    edge_pulse_gen #(.DW(4), .PW(pw_of(g))) u_dut (
      .clk(clk), .nreset(nreset), .en(en), .mode(mode), .clr(clr), .in(in_v),
      .edge_det(edge_a[g]), .out(out_a[g]), .retrig(ret_a[g])
    );
  end

  edge_pulse_gen #(.DW(1), .PW(1)) u_one (
    .clk(clk), .nreset(nreset), .en(en), .mode(mode), .clr(clr), .in(in_v[0]),
    .edge_det(e_one), .out(o_one), .retrig(r_one)
  );

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model + per-cycle scoreboard ----------------
  // A channel's pulse is alive while fewer than PW cycles have passed since its last edge.
  logic [3:0] m_prev = '0;
  bit         m_primed = 1'b0;
  int         m_last [NI][4];
  bit         m_ret  [NI][4];
  int         cyc_n = 0;

  initial begin
    for (int k = 0; k < NI; k++)
      for (int c = 0; c < 4; c++) begin
        m_last[k][c] = -1000;
        m_ret[k][c]  = 1'b0;
      end
  end

  always @(negedge clk) begin
    logic [3:0] rise_v, fall_v, det_v, exp_edge, exp_out, exp_ret, mask;
    logic [3:0] act_e, act_o, act_r;
    rise_v = in_v & ~m_prev;
    fall_v = ~in_v & m_prev;
    case (mode)
      2'b00:   det_v = rise_v;
      2'b01:   det_v = fall_v;
      2'b10:   det_v = rise_v | fall_v;
      default: det_v = 4'b0000;
    endcase
    exp_edge = (nreset && en && m_primed) ? det_v : 4'b0000;
    for (int k = 0; k < NI; k++) begin
      mask = (k == NI - 1) ? 4'b0001 : 4'b1111;
      for (int c = 0; c < 4; c++) begin
        exp_out[c] = nreset && (exp_edge[c] || (cyc_n - m_last[k][c] < pw_of(k)));
        exp_ret[c] = m_ret[k][c];
      end
      if (k < 5) begin
        act_e = edge_a[k];
        act_o = out_a[k];
        act_r = ret_a[k];
      end else begin
        act_e = {3'b000, e_one};
        act_o = {3'b000, o_one};
        act_r = {3'b000, r_one};
      end
      check($sformatf("model_edge[%0d]", k), act_e, exp_edge & mask);
      check($sformatf("model_out[%0d]", k),  act_o, exp_out & mask);
      check($sformatf("model_retrig[%0d]", k), act_r, exp_ret & mask);
    end
    // advance the model to the state after the coming rising edge
    for (int k = 0; k < NI; k++) begin
      for (int c = 0; c < 4; c++) begin
        if (!nreset) begin
          m_ret[k][c]  = 1'b0;
          m_last[k][c] = -1000;
        end else begin
          if (exp_edge[c] && (cyc_n - m_last[k][c] < pw_of(k))) m_ret[k][c] = 1'b1;
          else if (clr) m_ret[k][c] = 1'b0;
          if (exp_edge[c]) m_last[k][c] = cyc_n;
        end
      end
    end
    if (!nreset) begin
      m_primed = 1'b0;
    end else begin
      m_primed = 1'b1;
      m_prev   = in_v;
    end
    cyc_n++;
  end

  // ---------------- driver ----------------
  task automatic cycle(input logic nr, input logic e, input logic [1:0] m,
                       input logic c, input logic [3:0] i);
    @(posedge clk);
    #1;
    nreset = nr;
    en     = e;
    mode   = m;
    clr    = c;
    in_v   = i;
    @(negedge clk);
  endtask

  // ---------------- directed stimulus with literal pins ----------------
  initial begin
    // DW=1 PW=1, falling edge
    cycle(0, 1, 2'b01, 0, 4'b0000);
    cycle(0, 1, 2'b01, 0, 4'b0000);
    check("reset_out_pw3", out_a[1], 4'b0000);
    check("reset_ret_pw3", ret_a[1], 4'b0000);
    cycle(1, 1, 2'b01, 0, 4'b0001);
    check("prime_edge_one", {3'b0, e_one}, 4'b0000);
    cycle(1, 1, 2'b01, 0, 4'b0001);
    cycle(1, 1, 2'b01, 0, 4'b0000);
    check("fall_edge_one", {3'b0, e_one}, 4'b0001);
    check("fall_out_one", {3'b0, o_one}, 4'b0001);
    cycle(1, 1, 2'b01, 0, 4'b0000);
    check("after_out_one", {3'b0, o_one}, 4'b0000);
    check("after_ret_one", {3'b0, r_one}, 4'b0000);

    // DW=4 PW=3, both edges, retrigger on ch0
    repeat (3) cycle(1, 1, 2'b10, 0, 4'b0000);
    cycle(1, 1, 2'b10, 0, 4'b0101);
    check("both_t0_edge", edge_a[1], 4'b0101);
    check("both_t0_out", out_a[1], 4'b0101);
    cycle(1, 1, 2'b10, 0, 4'b0100);
    check("both_t1_edge", edge_a[1], 4'b0001);
    check("both_t1_ret", ret_a[1], 4'b0000);
    cycle(1, 1, 2'b10, 0, 4'b0100);
    check("both_t2_out", out_a[1], 4'b0101);
    check("both_t2_ret", ret_a[1], 4'b0001);
    cycle(1, 1, 2'b10, 0, 4'b0100);
    check("both_t3_out", out_a[1], 4'b0001);
    cycle(1, 1, 2'b10, 0, 4'b0100);
    check("both_t4_out", out_a[1], 4'b0000);
    check("both_t4_ret", ret_a[1], 4'b0001);
    cycle(1, 1, 2'b10, 1, 4'b0100);
    cycle(1, 1, 2'b10, 0, 4'b0100);
    check("clr_alone_ret", ret_a[1], 4'b0000);

    // set and clr in the same cycle: set wins
    cycle(1, 1, 2'b10, 0, 4'b0101);
    cycle(1, 1, 2'b10, 1, 4'b0100);
    cycle(1, 1, 2'b10, 0, 4'b0100);
    check("set_beats_clr", ret_a[1], 4'b0001);
    cycle(1, 1, 2'b10, 0, 4'b0100);
    cycle(1, 1, 2'b10, 0, 4'b0100);
    cycle(1, 1, 2'b10, 1, 4'b0100);
    check("held_before_clr", ret_a[1], 4'b0001);
    cycle(1, 1, 2'b10, 0, 4'b0100);
    check("later_clr_ret", ret_a[1], 4'b0000);

    // PW=4, input high through reset release
    cycle(0, 1, 2'b00, 0, 4'b1111);
    check("rst_hi_edge", edge_a[2], 4'b0000);
    check("rst_hi_out", out_a[2], 4'b0000);
    cycle(0, 1, 2'b00, 0, 4'b1111);
    cycle(1, 1, 2'b00, 0, 4'b1111);
    check("prime_hi_edge", edge_a[2], 4'b0000);
    cycle(1, 1, 2'b00, 0, 4'b1111);
    check("post_prime_edge", edge_a[2], 4'b0000);
    cycle(1, 1, 2'b00, 0, 4'b0000);
    check("fall_in_rise_mode", edge_a[2], 4'b0000);
    cycle(1, 1, 2'b00, 0, 4'b1111);
    check("rerise_edge", edge_a[2], 4'b1111);
    check("rerise_out", out_a[2], 4'b1111);
    repeat (3) cycle(1, 1, 2'b00, 0, 4'b1111);
    check("pw4_last_out", out_a[2], 4'b1111);
    cycle(1, 1, 2'b00, 0, 4'b1111);
    check("pw4_end_out", out_a[2], 4'b0000);

    // PW=5, en drops mid-pulse, then mode 11
    repeat (2) cycle(1, 1, 2'b00, 0, 4'b0000);
    cycle(1, 1, 2'b00, 0, 4'b0001);
    check("pw5_start_out", out_a[3], 4'b0001);
    cycle(1, 0, 2'b00, 0, 4'b0001);
    cycle(1, 0, 2'b00, 0, 4'b0000);
    cycle(1, 0, 2'b00, 0, 4'b0001);
    check("en0_no_edge", edge_a[3], 4'b0000);
    check("en0_out_runs", out_a[3], 4'b0001);
    cycle(1, 0, 2'b00, 0, 4'b0001);
    check("pw5_last_out", out_a[3], 4'b0001);
    cycle(1, 0, 2'b00, 0, 4'b0001);
    check("pw5_end_out", out_a[3], 4'b0000);
    for (int n = 0; n < 4; n++) begin
      cycle(1, 1, 2'b11, 0, (n % 2 == 0) ? 4'b0000 : 4'b1111);
      check("mode_none_edge", edge_a[3], 4'b0000);
      check("mode_none_out", out_a[3], 4'b0000);
    end

    // PW=6, reset mid-pulse with a retrigger pending
    cycle(1, 1, 2'b00, 0, 4'b0000);
    cycle(1, 1, 2'b00, 0, 4'b0001);
    cycle(1, 1, 2'b00, 0, 4'b0000);
    cycle(1, 1, 2'b00, 0, 4'b0001);
    cycle(1, 1, 2'b00, 0, 4'b0001);
    check("pw6_ret_set", ret_a[4], 4'b0001);
    check("pw6_out_hi", out_a[4], 4'b0001);
    cycle(0, 1, 2'b00, 0, 4'b0001);
    check("rst_mid_out", out_a[4], 4'b0000);
    check("rst_mid_edge", edge_a[4], 4'b0000);
    cycle(0, 1, 2'b00, 0, 4'b0001);
    check("rst_mid_ret", ret_a[4], 4'b0000);
    cycle(1, 1, 2'b00, 0, 4'b0001);
    check("prime_mid_out", out_a[4], 4'b0000);
    check("prime_mid_ret", ret_a[4], 4'b0000);
    cycle(1, 1, 2'b00, 0, 4'b0000);
    cycle(1, 1, 2'b00, 0, 4'b0001);
    check("pw6_new_edge", edge_a[4], 4'b0001);
    check("pw6_new_out", out_a[4], 4'b0001);
    repeat (5) cycle(1, 1, 2'b00, 0, 4'b0001);
    check("pw6_last_out", out_a[4], 4'b0001);
    cycle(1, 1, 2'b00, 0, 4'b0001);
    check("pw6_end_out", out_a[4], 4'b0000);

    repeat (2) cycle(1, 1, 2'b00, 0, 4'b0001);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
